// File: rtl/digit_entry_encoder.sv
// Collects one or two BCD keypad digits and commits them as a binary value on enter.
// A partial entry left idle too long is discarded by an inactivity timer.
module digit_entry_encoder #(
    parameter int DATA_W         = 5,
    parameter int MAX_VALUE      = 15,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        digit_in,
    input  logic              digit_valid,
    input  logic              enter,
    input  logic              clear,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              error,
    output logic              timeout,
    output logic [1:0]        entry_count
);

    // state | meaning
    // IDLE  | no digits held
    // ONE   | first digit held
    // TWO   | first and second digits held
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] TWO  = 2'd2;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TIMEOUT_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]        state, state_nx;
    logic [3:0]        first, first_nx;
    logic [3:0]        second, second_nx;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic [DATA_W-1:0] data_nx;
    logic              data_valid_nx, error_nx, timeout_nx;
    logic [6:0]        value;
    logic              digit_ok;
    logic              timer_at_last;

    // Held digits are always 0..9, so the two-digit value never exceeds 99.
    assign value         = (state == TWO) ? (7'(first) * 7'd10 + 7'(second)) : 7'(first);
    assign digit_ok      = (digit_in <= 4'd9);
    assign timer_at_last = TIMEOUT_EN && (timer == TMR_LAST);
    assign entry_count   = state;

    always_comb begin
        state_nx      = state;
        first_nx      = first;
        second_nx     = second;
        data_nx       = data;
        data_valid_nx = 1'b0;
        error_nx      = 1'b0;
        timeout_nx    = 1'b0;
        // Saturating count so a rejected digit on the last cycle still lets the timeout fire next.
        if (state == IDLE || !TIMEOUT_EN) begin
            timer_nx = '0;
        end else if (timer_at_last) begin
            timer_nx = timer;
        end else begin
            timer_nx = timer + TMR_W'(1);
        end

        if (clear) begin
            state_nx = IDLE;
            timer_nx = '0;
        end else if (enter) begin
            timer_nx = '0;
            if (state != IDLE) begin
                state_nx = IDLE;
                if (value <= 7'(MAX_VALUE)) begin
                    data_nx       = DATA_W'(value);
                    data_valid_nx = 1'b1;
                end else begin
                    error_nx = 1'b1;
                end
            end
        end else if (digit_valid) begin
            if (!digit_ok || state == TWO) begin
                error_nx = 1'b1;
            end else if (state == IDLE) begin
                first_nx = digit_in;
                state_nx = ONE;
                timer_nx = '0;
            end else begin
                second_nx = digit_in;
                state_nx  = TWO;
                timer_nx  = '0;
            end
        end else if (state != IDLE && timer_at_last) begin
            state_nx   = IDLE;
            timeout_nx = 1'b1;
            timer_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            first      <= '0;
            second     <= '0;
            timer      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            first      <= first_nx;
            second     <= second_nx;
            timer      <= timer_nx;
            data       <= data_nx;
            data_valid <= data_valid_nx;
            error      <= error_nx;
            timeout    <= timeout_nx;
        end
    end

endmodule
